// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared view-mode and control-state types for the sobel mode controller
package sobel_pkg;

  typedef enum logic [2:0] {
    VIEW_PASS  = 3'd0,
    VIEW_GRAY  = 3'd1,
    VIEW_BLUR  = 3'd2,
    VIEW_SOBEL = 3'd4
  } view_mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } ctrl_state_t;

  // Unknown switch codes fall back to pass-through rather than an undefined view.
  function automatic view_mode_t validate_view(input logic [7:0] code);
    case (code)
      8'd1:    return VIEW_GRAY;
      8'd2:    return VIEW_BLUR;
      8'd4:    return VIEW_SOBEL;
      default: return VIEW_PASS;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch debouncer producing a validated view request
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_i,
  output logic [2:0] req_o
);
  import sobel_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [7:0]    sw_q;
  logic [CW-1:0] cnt;

  // The counter saturates at LAST; every further equal sample re-latches the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q  <= 8'd0;
      cnt   <= '0;
      req_o <= 3'd0;
    end else begin
      sw_q <= sw_i;
      if (sw_i != sw_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        req_o <= validate_view(sw_q);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_mode_ctrl.sv
// rtl/sobel_mode_ctrl.sv - vsync-aligned view switching and resolution lock; SOBEL_SETTLE_BLANK_EN enables post-switch blanking
module sobel_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_FRAMES   = 2,
  parameter int CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sw_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [2:0]       mode_o,
  output logic             mode_change_o,
  output logic             blank_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic             locked_o
);
  import sobel_pkg::*;

  if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 15) begin : g_bad_settle
    $error("SETTLE_FRAMES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       unused_hs;
  logic [2:0] req_raw;
  view_mode_t req;
  logic       vs_q, dv_q, vs_rise, dv_fall;

  assign unused_hs = hs_i;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .sw_i  (sw_i),
    .req_o (req_raw)
  );

  assign req     = view_mode_t'(req_raw);
  assign vs_rise = vs_i & ~vs_q;
  assign dv_fall = dv_q & ~dv_i;

  logic [CNT_W-1:0] pix_cnt, line_cnt, prev_w, prev_h;
  logic [CNT_W-1:0] width_nxt, height_nxt;

  // A line ending on the vsync edge still belongs to the frame being closed.
  always_comb begin
    width_nxt  = dv_fall ? pix_cnt : width_o;
    height_nxt = (dv_fall && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= 1'b0;
      dv_q     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      prev_w   <= '0;
      prev_h   <= '0;
      width_o  <= '0;
      height_o <= '0;
      locked_o <= 1'b0;
    end else begin
      vs_q    <= vs_i;
      dv_q    <= dv_i;
      width_o <= width_nxt;
      if (dv_i) begin
        if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_W'(1);
      end else if (dv_fall) begin
        pix_cnt <= '0;
      end
      if (vs_rise) begin
        height_o <= height_nxt;
        line_cnt <= '0;
        locked_o <= (width_nxt == prev_w) && (height_nxt == prev_h) &&
                    (width_nxt != '0) && (height_nxt != '0);
        prev_w   <= width_nxt;
        prev_h   <= height_nxt;
      end else begin
        line_cnt <= height_nxt;
      end
    end
  end

  ctrl_state_t state, state_n;
  view_mode_t  mode_q, mode_n;
  logic        change_n;

`ifdef SOBEL_SETTLE_BLANK_EN
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
  logic       blank_q, blank_n;
  logic [3:0] frame_cnt, frame_n;
  assign blank_o = blank_q;
`else
  assign blank_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      mode_q        <= VIEW_PASS;
      mode_change_o <= 1'b0;
`ifdef SOBEL_SETTLE_BLANK_EN
      blank_q       <= 1'b0;
      frame_cnt     <= 4'd0;
`endif
    end else begin
      state         <= state_n;
      mode_q        <= mode_n;
      mode_change_o <= change_n;
`ifdef SOBEL_SETTLE_BLANK_EN
      blank_q       <= blank_n;
      frame_cnt     <= frame_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    change_n = 1'b0;
`ifdef SOBEL_SETTLE_BLANK_EN
    blank_n  = blank_q;
    frame_n  = frame_cnt;
`endif
    case (state)
      RUN: begin
        if (req != mode_q) state_n = PENDING;
      end
      PENDING: begin
        // A request withdrawn before vsync is dropped silently.
        if (req == mode_q) begin
          state_n = RUN;
        end else if (vs_rise) begin
          mode_n   = req;
          change_n = 1'b1;
`ifdef SOBEL_SETTLE_BLANK_EN
          blank_n  = 1'b1;
          frame_n  = 4'd0;
          state_n  = SETTLE;
`else
          state_n  = RUN;
`endif
        end
      end
      SETTLE: begin
`ifdef SOBEL_SETTLE_BLANK_EN
        if (vs_rise) begin
          if (frame_cnt == SETTLE_LAST) begin
            blank_n = 1'b0;
            state_n = RUN;
          end else begin
            frame_n = frame_cnt + 4'd1;
          end
        end
`else
        state_n = RUN;
`endif
      end
      default: state_n = RUN;
    endcase
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_sobel_mode_ctrl.sv
// tb/tb_sobel_mode_ctrl.sv - self-checking bench for sobel_mode_ctrl
module tb_sobel_mode_ctrl;
  localparam int D  = 4;
  localparam int SF = 2;
  localparam int CW = 12;
`ifdef SOBEL_SETTLE_BLANK_EN
  localparam int BLANK_EN = 1;
`else
  localparam int BLANK_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, dv_i, hs_i, vs_i;
  logic [7:0]    sw_i;
  logic [2:0]    mode_o;
  logic          mode_change_o, blank_o, locked_o;
  logic [CW-1:0] width_o, height_o;

  always #5 clk = ~clk;

  sobel_mode_ctrl #(.DEBOUNCE_CYCLES(D), .SETTLE_FRAMES(SF), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_i          (sw_i),
    .dv_i          (dv_i),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .mode_o        (mode_o),
    .mode_change_o (mode_change_o),
    .blank_o       (blank_o),
    .width_o       (width_o),
    .height_o      (height_o),
    .locked_o      (locked_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int valid_code(input int c);
    return (c == 0 || c == 1 || c == 2 || c == 4) ? c : 0;
  endfunction

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  // Reference model: spec-level bookkeeping with plain integers.
  int m_sw_prev, m_run, m_req, m_mode, m_change, m_blank, m_armed, m_settle_left;
  int m_vs_prev, m_dv_prev, m_pix, m_width, m_lines, m_height, m_prev_w, m_prev_h, m_locked;
  int m_vs_rise, m_dv_fall, m_w_new, m_h_new;
  bit m_started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_sw_prev = 0; m_run = 0; m_req = 0; m_mode = 0; m_change = 0; m_blank = 0;
      m_armed = 0; m_settle_left = 0; m_vs_prev = 0; m_dv_prev = 0; m_pix = 0;
      m_width = 0; m_lines = 0; m_height = 0; m_prev_w = 0; m_prev_h = 0; m_locked = 0;
      m_started = 1'b1;
    end else begin
      m_vs_rise = (vs_i && !m_vs_prev) ? 1 : 0;
      m_dv_fall = (m_dv_prev && !dv_i) ? 1 : 0;
      m_w_new = m_dv_fall ? m_pix : m_width;
      m_h_new = m_dv_fall ? sat(m_lines + 1) : m_lines;
      if (dv_i) m_pix = sat(m_pix + 1);
      else if (m_dv_fall) m_pix = 0;
      m_width = m_w_new;
      if (m_vs_rise) begin
        m_locked = (m_w_new == m_prev_w && m_h_new == m_prev_h && m_w_new != 0 && m_h_new != 0) ? 1 : 0;
        m_height = m_h_new;
        m_prev_w = m_w_new;
        m_prev_h = m_h_new;
        m_lines  = 0;
      end else begin
        m_lines = m_h_new;
      end
      m_change = 0;
      if (m_settle_left > 0) begin
        if (m_vs_rise) begin
          m_settle_left--;
          if (m_settle_left == 0) m_blank = 0;
        end
      end else if (!m_armed) begin
        m_armed = (m_req != m_mode) ? 1 : 0;
      end else if (m_req == m_mode) begin
        m_armed = 0;
      end else if (m_vs_rise) begin
        m_mode = m_req;
        m_change = 1;
        m_armed = 0;
        if (BLANK_EN != 0) begin
          m_settle_left = SF;
          m_blank = 1;
        end
      end
      if (int'(sw_i) == m_sw_prev) begin
        if (m_run < D - 1) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= D - 1) m_req = valid_code(m_sw_prev);
      m_sw_prev = int'(sw_i);
      m_vs_prev = int'(vs_i);
      m_dv_prev = int'(dv_i);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("mode", mode_o, m_mode);
      check("mode_change", mode_change_o, m_change);
      check("blank", blank_o, m_blank);
      check("width", width_o, m_width);
      check("height", height_o, m_height);
      check("locked", locked_o, m_locked);
    end
    if (mode_change_o) n_pulses++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1; idle(4);
    vs_i = 1'b0; idle(4);
  endtask

  // last_on_vs: final line's dv falls in the same cycle vsync rises.
  task automatic frame(input int w, input int h, input bit last_on_vs);
    for (int l = 0; l < h; l++) begin
      dv_i = 1'b1; idle(w);
      dv_i = 1'b0;
      if (last_on_vs && l == h - 1) begin
        vs_i = 1'b1; idle(4);
        vs_i = 1'b0; idle(4);
      end else begin
        hs_i = 1'b1; idle(2);
        hs_i = 1'b0; idle(6);
      end
    end
    if (!last_on_vs) vs_pulse();
  endtask

  initial begin
    rst = 1'b1; sw_i = 8'd0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(20);
    check("idle_mode", mode_o, 0);
    check("idle_blank", blank_o, 0);
    check("idle_locked", locked_o, 0);
    check("idle_pulses", n_pulses, 0);

    sw_i = 8'd3; idle(10);
    vs_pulse();
    check("invalid_code_mode", mode_o, 0);
    check("invalid_code_pulses", n_pulses, 0);

    sw_i = 8'd4; idle(10);
    check("hold_until_vs", mode_o, 0);
    vs_i = 1'b1; idle(1);
    check("switch_mode", mode_o, 4);
    check("switch_pulse", mode_change_o, 1);
    check("switch_blank", blank_o, BLANK_EN);
    idle(3); vs_i = 1'b0; idle(4);
    check("single_pulse", n_pulses, 1);
    vs_pulse();
    check("blank_second_frame", blank_o, BLANK_EN);
    vs_pulse();
    check("blank_released", blank_o, 0);

    sw_i = 8'd1; idle(1);
    sw_i = 8'd4; idle(10);
    vs_pulse();
    check("glitch_mode", mode_o, 4);
    check("glitch_pulses", n_pulses, 1);

    frame(64, 48, 1'b0);
    check("frame1_height", height_o, 48);
    check("frame1_locked", locked_o, 0);
    frame(64, 48, 1'b0);
    check("frame2_locked", locked_o, 1);
    frame(64, 48, 1'b0);
    check("frame3_width", width_o, 64);
    check("frame3_height", height_o, 48);
    check("frame3_locked", locked_o, 1);
    frame(65, 48, 1'b0);
    check("wide_width", width_o, 65);
    check("wide_locked", locked_o, 0);
    frame(64, 48, 1'b1);
    check("coincident_height", height_o, 48);
    check("coincident_locked", locked_o, 0);
    frame(64, 48, 1'b0);
    check("relock", locked_o, 1);

    sw_i = 8'd2; idle(10);
    vs_i = 1'b1; idle(1);
    check("pre_rst_mode", mode_o, 2);
    check("pre_rst_blank", blank_o, BLANK_EN);
    rst = 1'b1; idle(1);
    check("rst_mode", mode_o, 0);
    check("rst_blank", blank_o, 0);
    check("rst_locked", locked_o, 0);
    rst = 1'b0; vs_i = 1'b0; idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_mode_ctrl.md
Name: sobel_mode_ctrl

Overview:
- Control block in front of the sobel output multiplexer.
- Debounces the board switches and validates the requested view code.
- Applies a view change only at a vertical-sync rising edge, then blanks video for a settle period so the line buffers refill.
- Measures active width/height per frame and reports lock, so a changed mode never tears mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles sw_i must be stable before it is accepted.
- SETTLE_FRAMES, 2: frames blanked after a mode switch (range 1..15).
- CNT_W, 12: width of the resolution counters and outputs.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- sw_i  in  8  raw switch value
- dv_i  in  1  data valid, active high
- hs_i  in  1  hsync, already polarity-normalised (active high)
- vs_i  in  1  vsync, already polarity-normalised (active high)
- mode_o  out  3  applied view code: 0 pass, 1 gray, 2 blur, 4 sobel
- mode_change_o  out  1  one-cycle pulse when mode_o updates
- blank_o  out  1  force RGB to 0 downstream
- width_o  out  CNT_W  dv-high cycles in last complete line
- height_o  out  CNT_W  lines containing dv in last complete frame
- locked_o  out  1  two consecutive frames had identical nonzero width/height

Behaviour:
- Reset: all outputs 0; FSM=RUN; counters 0; accepted request=0.
- Debounce:
  - Register sw_i once.
  - Counter restarts on any change; at DEBOUNCE_CYCLES-1 equal samples, latch req.
  - Codes other than 0,1,2,4 map to 0.
- vs edge: vs_rise = vs_i & ~vs_q (vs_q registered).
- FSM states:
  - RUN: if req != mode_o, go to PENDING.
  - PENDING:
    - On vs_rise: mode_o <= req, pulse mode_change_o, frame_cnt <= 0, go to SETTLE.
    - If req returns to mode_o before vs_rise, go back to RUN with no pulse.
  - SETTLE:
    - blank_o=1.
    - Each vs_rise increments frame_cnt.
    - At frame_cnt==SETTLE_FRAMES-1 and vs_rise: blank_o<=0, go to RUN.
    - A new req differing from mode_o in SETTLE is held; it is evaluated after returning to RUN.
- Output timing: blank_o and mode_o change on the same clock edge (registered, 1 cycle after the vs_rise sample).
- Width measurement:
  - pix_cnt increments while dv_i=1.
  - On dv falling edge: width_o <= pix_cnt, pix_cnt <= 0.
  - Saturates at all-ones.
- Height measurement:
  - line_cnt increments on each dv falling edge.
  - On vs_rise: height_o <= line_cnt, line_cnt <= 0.
  - Saturates at all-ones.
- Lock:
  - On vs_rise, compare the new width/height with the previous frame's.
  - locked_o=1 if equal and both nonzero, else 0.
  - First frame after reset: locked_o=0.
- Simultaneous events:
  - dv falling edge and vs_rise in the same cycle: the line is counted into the frame being closed.
  - Debounce latch and vs_rise in the same cycle: the new req is used in the next cycle (no same-cycle bypass).
- Reset mid-SETTLE: immediate return to RUN, mode_o=0, blank_o=0.
- No vs_i activity: PENDING persists indefinitely; mode_o does not change.

Optional Feature:
- Macro SOBEL_SETTLE_BLANK_EN.
- Defined: SETTLE state and blank_o behave as described.
- Undefined:
  - blank_o is tied 0.
  - PENDING goes directly to RUN on vs_rise after updating mode_o.
  - SETTLE_FRAMES is ignored.

Decomposition:
- Package sobel_pkg:
  - typedef enum logic [2:0] view_mode_t {VIEW_PASS=0, VIEW_GRAY=1, VIEW_BLUR=2, VIEW_SOBEL=4}
  - typedef enum logic [1:0] ctrl_state_t {RUN, PENDING, SETTLE}
  - function for code validation.
- One sub-module, sw_debounce (parameter DEBOUNCE_CYCLES, width 8), instantiated once.
- FSM and resolution counters stay in the top of this block.

Test Plan:
- Reset then idle -> mode_o=0, blank_o=0, locked_o=0, mode_change_o never pulses.
- DEBOUNCE_CYCLES=4; sw_i=4 held 10 cycles mid-frame -> mode_o stays 0 until next vs_rise, then mode_o=4 with one mode_change_o pulse.
- With the macro and SETTLE_FRAMES=2:
  - Expect blank_o=1 for exactly 2 frames after the switch, deasserting on the second vs_rise.
  - Same stimulus without the macro -> blank_o stays 0.
- sw_i=3 (invalid) stable -> treated as 0; no change if mode_o=0.
- sw_i glitches 4→1→4 within 3 cycles -> no accepted change.
- Frames of 640 dv cycles × 480 lines repeated 3× -> width_o=640, height_o=480, locked_o=1 from the 2nd vs_rise.
  - Then one 641-cycle frame -> locked_o=0 at the following vs_rise.
- Assert rst during SETTLE -> next cycle mode_o=0, blank_o=0, state RUN.
